channel_frame_collector: RTL and testbench
==========================================

# channel_frame_collector

Collects the time-multiplexed per-channel sample stream produced at the tail of the operator/channel pipeline into one parallel frame of NUM_SLOTS samples. It presents that frame to the output stage (DAC/I2S formatter) over a valid/ready handshake. It is the reading end of the slot-serial pipeline: upstream shifts one slot per enabled beat, and this block reassembles the slots. Frame sync, completeness and back-pressure are checked, and violations are flagged.

## Interface
- DATA_WIDTH, 16, width of one channel sample (signed, passed through untouched)
- NUM_SLOTS, 18, slots per frame; must be ≥ 2; index width IDX_W = $clog2(NUM_SLOTS) (derived localparam)
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse marking slot 0 of a new frame
- in_valid  in  1  in_data carries the next slot sample this cycle
- in_data  in  DATA_WIDTH  slot sample
- out_valid  out  1  out_data holds a complete frame
- out_ready  in  1  consumer accepts frame when out_valid && out_ready
- out_data  out  [NUM_SLOTS-1:0][DATA_WIDTH-1:0]  frame, element i = slot i
- frame_error  out  1  one-cycle pulse: frame restarted before completion
- overrun  out  1  one-cycle pulse: input data dropped because a completed frame could not be published

## Operation
- Reset (async assert, sync release): state IDLE, idx 0, shadow bank all 0, out_data all 0, out_valid 0, frame_error 0, overrun 0.
- States:
  - IDLE: waits for frame_start. in_valid without frame_start is ignored silently.
  - COLLECT: accepts slots into the shadow bank.
  - PUBLISH: holds a complete shadow frame while the output bank is still occupied.
- frame_start in IDLE:
  - go to COLLECT with idx 0.
  - If in_valid is high in the same cycle, that beat is slot 0: shadow[0] <= in_data, idx <= 1.
- COLLECT, in_valid beat: shadow[idx] <= in_data, idx++. Beats with in_valid=0 hold idx.
- Last beat (idx == NUM_SLOTS-1 with in_valid):
  - If the output bank is free this cycle (!out_valid || out_ready), copy shadow (with the last beat merged) to out_data, set out_valid, go to IDLE.
  - Otherwise, write the beat to shadow and go to PUBLISH.
- frame_start in COLLECT before completion:
  - pulse frame_error.
  - restart at idx 0; a same-cycle in_valid beat is slot 0.
  - partial shadow contents are not cleared; they are overwritten.
- PUBLISH: when !out_valid || out_ready, out_data <= shadow, out_valid <= 1, go to IDLE.
- Any frame_start or in_valid received while in PUBLISH:
  - pulse overrun; the pending shadow frame is kept and the input is dropped.
  - frame_start is not latched; the next frame begins only with a frame_start seen in IDLE.
- out_valid clears on out_valid && out_ready unless a publish happens in the same cycle, in which case it stays 1 with new data.
- out_data is stable while out_valid && !out_ready.
- idx never exceeds NUM_SLOTS-1; there is no wrap-around inside a frame, and completion always returns to IDLE.

## Timing
- Publish latency: 1 cycle after the last slot beat if the output bank is free (out_valid=1 and new out_data visible at edge t+1).
- If the output bank is busy, publish occurs 1 cycle after the cycle in which out_ready is high (PUBLISH→IDLE).
- Minimum frame period without overrun: NUM_SLOTS beats plus 0 idle cycles, provided the consumer accepts within the frame time. Back-to-back frame_start directly after completion is legal because IDLE is entered at t+1.
  - frame_start at cycle t+1 is accepted.
  - frame_start at cycle t (the same cycle as the last beat) is a frame_error.
- frame_error and overrun are registered, high for exactly the cycle after the offending event.
- reset_n asserted mid-frame or mid-publish: all state and outputs return to reset values immediately. No partial frame is published after release.

## Test plan
- Normal frame:
  - Stimulus: frame_start with in_valid, then 18 consecutive beats with data 0x0100+i, out_ready=1.
  - Required response: out_valid high exactly one cycle after beat 17; out_data[i]=0x0100+i; no error pulses.
- Gapped input: same frame with in_valid deasserted on every other cycle -> identical out_data; out_valid one cycle after the 18th valid beat.
- Early restart:
  - Stimulus: frame_start, 7 beats, then frame_start plus 18 beats of 0x2000+i.
  - Required response: one frame_error pulse; published frame is 0x2000+i for all slots.
- Back-pressure:
  - Stimulus: out_ready=0, two complete frames A then B, then out_ready=1.
  - Required response: frame A held stable; B enters PUBLISH. Beats of a third frame started during PUBLISH each pulse overrun. After A is accepted, out_data=B one cycle later.
- Simultaneous accept and publish:
  - Stimulus: out_ready=1 in the same cycle as a new frame's last beat, while the old frame is valid.
  - Required response: out_valid stays 1 and out_data switches to the new frame at t+1.
- Async reset at beat 9 of a frame -> out_valid=0 and out_data=0 immediately. The next full frame after release publishes correctly with no stale slots.

Source files
------------

// File: rtl/channel_frame_collector_if.sv
// Bus bundle for the frame collector: slot-serial input stream, parallel frame
// output handshake and the two error pulses.
interface channel_frame_collector_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_SLOTS  = 18
);
    logic                                  frame_start;
    logic                                  in_valid;
    logic [DATA_WIDTH-1:0]                 in_data;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [NUM_SLOTS-1:0][DATA_WIDTH-1:0]  out_data;
    logic                                  frame_error;
    logic                                  overrun;

    // Producer of slot samples and consumer of frames.
    modport master (
        output frame_start, in_valid, in_data, out_ready,
        input  out_valid, out_data, frame_error, overrun
    );

    // The collector itself.
    modport slave (
        input  frame_start, in_valid, in_data, out_ready,
        output out_valid, out_data, frame_error, overrun
    );
endinterface

// File: rtl/channel_frame_collector.sv
// Reassembles the slot-serial sample stream into a parallel frame of NUM_SLOTS
// samples and hands it to the output stage over valid/ready. A shadow bank
// collects slots; a separate output bank holds the published frame.
module channel_frame_collector #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned NUM_SLOTS  = 18
) (
    input logic                     clk,
    input logic                     reset_n,
    channel_frame_collector_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_SLOTS);
    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_SLOTS - 1);

    typedef logic [NUM_SLOTS-1:0][DATA_WIDTH-1:0] frame_t;
    typedef enum logic [1:0] {StIdle, StCollect, StPublish} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    frame_t            shadow_q, shadow_d;
    frame_t            out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;
    logic              frame_error_q, frame_error_d;
    logic              overrun_q, overrun_d;
    logic              bank_free;

    // Output bank can take a new frame when empty or being drained this cycle.
    assign bank_free = !out_valid_q || bus.out_ready;

    // Next-state: slot collection, publish decision and error pulses.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        shadow_d      = shadow_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q && !bus.out_ready;
        frame_error_d = 1'b0;
        overrun_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.frame_start) begin
                    state_d = StCollect;
                    idx_d   = '0;
                    if (bus.in_valid) begin
                        shadow_d[0] = bus.in_data;
                        idx_d       = IDX_W'(1);
                    end
                end
            end

            StCollect: begin
                if (bus.frame_start) begin
                    // Restart wins even over a would-be last beat; stale slots
                    // are simply overwritten by the new frame.
                    frame_error_d = 1'b1;
                    idx_d         = '0;
                    if (bus.in_valid) begin
                        shadow_d[0] = bus.in_data;
                        idx_d       = IDX_W'(1);
                    end
                end else if (bus.in_valid) begin
                    shadow_d[idx_q] = bus.in_data;
                    if (idx_q == LastIdx) begin
                        idx_d = '0;
                        if (bank_free) begin
                            out_data_d  = shadow_d;
                            out_valid_d = 1'b1;
                            state_d     = StIdle;
                        end else begin
                            state_d = StPublish;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            StPublish: begin
                // Input arriving while a complete frame is stuck is dropped.
                if (bus.frame_start || bus.in_valid) begin
                    overrun_d = 1'b1;
                end
                if (bank_free) begin
                    out_data_d  = shadow_q;
                    out_valid_d = 1'b1;
                    state_d     = StIdle;
                end
            end

            default: begin
                state_d = StIdle;
                idx_d   = '0;
            end
        endcase
    end

    // State and bank registers with asynchronous reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            shadow_q      <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            frame_error_q <= frame_error_d;
            overrun_q     <= overrun_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_data    = out_data_q;
    assign bus.frame_error = frame_error_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_channel_frame_collector.sv
// Bench for channel_frame_collector: directed scenarios plus random traffic,
// checked every cycle against a queue-based frame model.
module tb_channel_frame_collector;
    localparam int DW = 16;
    localparam int NS = 18;

    typedef logic [NS-1:0][DW-1:0] frame_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    channel_frame_collector_if #(.DATA_WIDTH(DW), .NUM_SLOTS(NS)) bus ();

    channel_frame_collector #(.DATA_WIDTH(DW), .NUM_SLOTS(NS)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Model: a frame in progress is a queue of samples, a stuck complete frame
    // is an optional pending frame, and the output is a valid flag plus frame.
    bit             m_collecting;
    bit             m_pending;
    frame_t         m_pend_frame;
    logic [DW-1:0]  cur[$];
    bit             m_out_valid;
    frame_t         m_out_data;
    bit             m_ferr;
    bit             m_ovr;

    function automatic frame_t ramp(input logic [DW-1:0] base);
        frame_t f;
        for (int i = 0; i < NS; i++) f[i] = base + DW'(i);
        return f;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_collecting = 0;
            m_pending    = 0;
            m_pend_frame = '0;
            cur.delete();
            m_out_valid  = 0;
            m_out_data   = '0;
            m_ferr       = 0;
            m_ovr        = 0;
        end else begin
            bit     fs, iv, rdy, free, nv;
            frame_t nd;
            logic [DW-1:0] d;
            fs   = bus.frame_start;
            iv   = bus.in_valid;
            rdy  = bus.out_ready;
            d    = bus.in_data;
            free = !m_out_valid || rdy;
            nv   = m_out_valid && !rdy;
            nd   = m_out_data;
            m_ferr = 0;
            m_ovr  = 0;
            if (m_pending) begin
                if (fs || iv) m_ovr = 1;
                if (free) begin
                    nd = m_pend_frame;
                    nv = 1;
                    m_pending = 0;
                end
            end else if (fs) begin
                if (m_collecting) m_ferr = 1;
                cur.delete();
                m_collecting = 1;
                if (iv) cur.push_back(d);
            end else if (m_collecting && iv) begin
                cur.push_back(d);
                if (cur.size() == NS) begin
                    frame_t f;
                    for (int i = 0; i < NS; i++) f[i] = cur[i];
                    if (free) begin
                        nd = f;
                        nv = 1;
                    end else begin
                        m_pend_frame = f;
                        m_pending = 1;
                    end
                    m_collecting = 0;
                    cur.delete();
                end
            end
            m_out_valid = nv;
            m_out_data  = nd;
        end
    end

    task automatic chk_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_frame(input string name, input frame_t act, input frame_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    bit run_cmp = 0;
    always @(negedge clk) begin
        if (run_cmp && reset_n) begin
            chk_bit("model out_valid", bus.out_valid, m_out_valid);
            chk_frame("model out_data", bus.out_data, m_out_data);
            chk_bit("model frame_error", bus.frame_error, m_ferr);
            chk_bit("model overrun", bus.overrun, m_ovr);
        end
    end

    task automatic beat(input logic fs, input logic iv, input logic [DW-1:0] d,
                        input logic rdy);
        bus.frame_start = fs;
        bus.in_valid    = iv;
        bus.in_data     = d;
        bus.out_ready   = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [DW-1:0] base, input bit gap,
                              input logic rdy, input logic rdy_last);
        beat(1'b1, 1'b1, base, rdy);
        for (int i = 1; i < NS; i++) begin
            if (gap) beat(1'b0, 1'b0, '0, rdy);
            beat(1'b0, 1'b1, base + DW'(i), (i == NS - 1) ? rdy_last : rdy);
        end
    endtask

    initial begin
        bus.frame_start = 0;
        bus.in_valid    = 0;
        bus.in_data     = '0;
        bus.out_ready   = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_bit("reset out_valid", bus.out_valid, 1'b0);
        chk_frame("reset out_data", bus.out_data, '0);
        chk_bit("reset frame_error", bus.frame_error, 1'b0);
        chk_bit("reset overrun", bus.overrun, 1'b0);
        reset_n = 1'b1;
        run_cmp = 1;
        beat(0, 0, '0, 1);

        // Normal frame.
        send_frame(16'h0100, 0, 1, 1);
        chk_bit("normal valid", bus.out_valid, 1'b1);
        chk_frame("normal data", bus.out_data, ramp(16'h0100));
        beat(0, 0, '0, 1);
        chk_bit("normal drained", bus.out_valid, 1'b0);

        // Gapped input.
        send_frame(16'h0100, 1, 1, 1);
        chk_bit("gapped valid", bus.out_valid, 1'b1);
        chk_frame("gapped data", bus.out_data, ramp(16'h0100));
        beat(0, 0, '0, 1);

        // Early restart after 7 beats.
        beat(1, 1, 16'h1000, 1);
        for (int i = 1; i < 7; i++) beat(0, 1, 16'h1000 + DW'(i), 1);
        beat(1, 1, 16'h2000, 1);
        chk_bit("restart frame_error", bus.frame_error, 1'b1);
        for (int i = 1; i < NS; i++) begin
            beat(0, 1, 16'h2000 + DW'(i), 1);
            if (i == 1) chk_bit("restart pulse ends", bus.frame_error, 1'b0);
        end
        chk_frame("restart data", bus.out_data, ramp(16'h2000));
        beat(0, 0, '0, 1);

        // Back-pressure: A held, B pending, third frame overruns.
        send_frame(16'hA000, 0, 0, 0);
        chk_frame("bp A out", bus.out_data, ramp(16'hA000));
        send_frame(16'hB000, 0, 0, 0);
        chk_frame("bp A held", bus.out_data, ramp(16'hA000));
        beat(1, 1, 16'h5555, 0);
        chk_bit("bp overrun fs", bus.overrun, 1'b1);
        beat(0, 1, 16'h5556, 0);
        chk_bit("bp overrun beat", bus.overrun, 1'b1);
        beat(0, 0, '0, 0);
        chk_bit("bp overrun idle", bus.overrun, 1'b0);
        chk_frame("bp A still", bus.out_data, ramp(16'hA000));
        beat(0, 0, '0, 1);
        chk_bit("bp B valid", bus.out_valid, 1'b1);
        chk_frame("bp B data", bus.out_data, ramp(16'hB000));
        beat(0, 0, '0, 1);
        chk_bit("bp drained", bus.out_valid, 1'b0);

        // Simultaneous accept and publish.
        send_frame(16'hC000, 0, 0, 0);
        send_frame(16'hD000, 0, 0, 1);
        chk_bit("simul valid", bus.out_valid, 1'b1);
        chk_frame("simul data", bus.out_data, ramp(16'hD000));
        beat(0, 0, '0, 1);

        // Async reset at beat 9 with a held frame on the output.
        send_frame(16'hE000, 0, 0, 0);
        beat(1, 1, 16'hF000, 0);
        for (int i = 1; i < 9; i++) beat(0, 1, 16'hF000 + DW'(i), 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk_bit("async rst valid", bus.out_valid, 1'b0);
        chk_frame("async rst data", bus.out_data, '0);
        bus.frame_start = 0;
        bus.in_valid    = 0;
        bus.out_ready   = 1;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        beat(0, 1, 16'h7777, 1);
        chk_bit("post rst no publish", bus.out_valid, 1'b0);
        send_frame(16'h3000, 0, 1, 1);
        chk_frame("post rst data", bus.out_data, ramp(16'h3000));
        beat(0, 0, '0, 1);

        // Random traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            beat(($urandom % 40) == 0, ($urandom % 4) != 0, DW'($urandom),
                 ($urandom % 3) != 0);
        end
        beat(0, 0, '0, 1);
        beat(0, 0, '0, 1);

        run_cmp = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
